// File: rtl/scene_pkg.sv
// scene_pkg: VGA 640x480@60 timing constants and scene geometry shared by the scanner files
package scene_pkg;
    localparam logic [8:0] SCENE_W   = 9'd320;
    localparam logic [8:0] SCENE_H   = 9'd240;
    localparam logic [9:0] H_VISIBLE = {SCENE_W, 1'b0};
    localparam logic [9:0] H_FRONT   = 10'd16;
    localparam logic [9:0] H_SYNC    = 10'd96;
    localparam logic [9:0] H_BACK    = 10'd48;
    localparam logic [9:0] H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam logic [9:0] V_VISIBLE = {SCENE_H, 1'b0};
    localparam logic [9:0] V_FRONT   = 10'd10;
    localparam logic [9:0] V_SYNC    = 10'd2;
    localparam logic [9:0] V_BACK    = 10'd33;
    localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int ADDR_W  = 17;
    localparam int OUT_DLY = 1;
    typedef logic [ADDR_W-1:0] scene_addr_t;
    typedef logic [9:0] cnt_t;
    typedef logic [OUT_DLY-1:0] dly_t;
    function automatic logic [8:0] scene_col(input logic [8:0] s);
        return s >= SCENE_W ? s - SCENE_W : s;
    endfunction
endpackage

// File: rtl/scene_scanner_vga_timing.sv
// vga_timing: h/v raster counters with next-state view, raw syncs and wrap strobe
module vga_timing
    import scene_pkg::*;
(
    input  logic vga_clk,
    input  logic reset,
    output cnt_t h_cnt,
    output cnt_t v_cnt,
    output cnt_t h_next,
    output cnt_t v_next,
    output logic frame_end,
    output logic vis_next,
    output logic hs_raw,
    output logic vs_raw
);
    logic run_q, run_d, line_end;
    cnt_t h_q, h_d, v_q, v_d;
    // the first edge after reset holds (0,0) so the opening pixel is shown with valid outputs
    always_comb begin
        run_d = 1'b1;
        line_end = h_q == H_TOTAL - 10'd1;
        frame_end = line_end && v_q == V_TOTAL - 10'd1;
        h_d = run_q && !line_end ? h_q + 10'd1 : '0;
        v_d = !run_q || frame_end ? '0 : line_end ? v_q + 10'd1 : v_q;
        vis_next = h_d < H_VISIBLE && v_d < V_VISIBLE;
        hs_raw = !(h_q >= H_VISIBLE + H_FRONT && h_q < H_VISIBLE + H_FRONT + H_SYNC);
        vs_raw = !(v_q >= V_VISIBLE + V_FRONT && v_q < V_VISIBLE + V_FRONT + V_SYNC);
    end
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            run_q <= 1'b0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            run_q <= run_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end
    assign h_cnt  = h_q;
    assign v_cnt  = v_q;
    assign h_next = h_d;
    assign v_next = v_d;
endmodule

// File: rtl/scene_scanner.sv
// scene_scanner: raster timing plus scrolled 2x2-texel scene ROM address, blank and delayed syncs
module scene_scanner
    import scene_pkg::*;
(
    input  logic        vga_clk,
    input  logic        reset,
    input  logic [8:0]  scroll_x,
    output scene_addr_t rom_address,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic [9:0]  draw_x,
    output logic [9:0]  draw_y,
    output logic        frame_start
);
    cnt_t h_q, v_q, h_d, v_d;
    logic frame_end, vis_d, hs_raw, vs_raw;
    logic [8:0] scroll_q, scroll_d, col_q, col_d, col_step;
    scene_addr_t base_q, base_d, addr_q, addr_d;
    logic blank_q, blank_d, fs_q, fs_d, line_start, frame_top;
    dly_t hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d;

    vga_timing u_timing (
        .vga_clk   (vga_clk),
        .reset     (reset),
        .h_cnt     (h_q),
        .v_cnt     (v_q),
        .h_next    (h_d),
        .v_next    (v_d),
        .frame_end (frame_end),
        .vis_next  (vis_d),
        .hs_raw    (hs_raw),
        .vs_raw    (vs_raw)
    );

    // everything is derived for the pixel the counters move to, so registered outputs line up with draw_x/draw_y
    always_comb begin
        line_start = h_d == '0;
        frame_top = line_start && v_d == '0;
        scroll_d = frame_end ? scene_col(scroll_x) : scroll_q;
        col_step = col_q == SCENE_W - 9'd1 ? '0 : col_q + 9'd1;
        col_d = line_start ? scroll_d : h_q[0] ? col_step : col_q;
        base_d = frame_top ? '0 :
                 line_start && v_q[0] && v_q < V_VISIBLE ? base_q + scene_addr_t'(SCENE_W) : base_q;
        addr_d = vis_d ? base_d + scene_addr_t'(col_d) : '0;
        blank_d = vis_d;
        fs_d = frame_top;
        hs_pipe_d = dly_t'({hs_pipe_q, hs_raw});
        vs_pipe_d = dly_t'({vs_pipe_q, vs_raw});
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            scroll_q  <= '0;
            col_q     <= '0;
            base_q    <= '0;
            addr_q    <= '0;
            blank_q   <= 1'b0;
            fs_q      <= 1'b0;
            hs_pipe_q <= '1;
            vs_pipe_q <= '1;
        end else begin
            scroll_q  <= scroll_d;
            col_q     <= col_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
            blank_q   <= blank_d;
            fs_q      <= fs_d;
            hs_pipe_q <= hs_pipe_d;
            vs_pipe_q <= vs_pipe_d;
        end
    end

    assign rom_address = addr_q;
    assign blank       = blank_q;
    assign frame_start = fs_q;
    assign hs          = hs_pipe_q[OUT_DLY-1];
    assign vs          = vs_pipe_q[OUT_DLY-1];
    assign draw_x      = h_q;
    assign draw_y      = v_q;
endmodule
